hilo_unit: RTL
==============

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 The block SHALL have parameter LENGTH, default 32, giving the HI/LO and operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port W_HILO, input, 1 bit: ALU write strobe for HI/LO.
REQ-005 The block SHALL have port Write_LO, input, LENGTH bits: value for LO when W_HILO=1.
REQ-006 The block SHALL have port Write_HI, input, LENGTH bits: value for HI when W_HILO=1.
REQ-007 The block SHALL have port div_start, input, 1 bit: one-cycle request to begin an iterative divide.
REQ-008 The block SHALL have port div_sign, input, 1 bit: 1 = signed divide, 0 = unsigned.
REQ-009 The block SHALL have port div_a, input, LENGTH bits: dividend, sampled at div_start.
REQ-010 The block SHALL have port div_b, input, LENGTH bits: divisor, sampled at div_start.
REQ-011 The block SHALL have port LO, output, LENGTH bits: registered LO value.
REQ-012 The block SHALL have port HI, output, LENGTH bits: registered HI value.
REQ-013 The block SHALL have port busy, output, 1 bit: divider active; the pipeline stalls on it.
REQ-014 The block SHALL have port div_done, output, 1 bit: one-cycle pulse in the cycle HI/LO take a divide result.

Function
REQ-015 The FSM SHALL have states IDLE, DIV and FINISH; busy SHALL be 1 in DIV and FINISH only.
REQ-016 In IDLE with W_HILO=1, HI<=Write_HI and LO<=Write_LO on the next edge.
REQ-017 In IDLE with div_start=1 and div_b!=0, operands SHALL latch and the FSM SHALL go to DIV with iteration count 0.
REQ-018 DIV SHALL perform one restoring shift-subtract step per cycle for exactly LENGTH cycles, then go to FINISH.
REQ-019 FINISH SHALL write LO<=quotient and HI<=remainder, pulse div_done, and return to IDLE; latency from div_start to updated HI/LO is LENGTH+2 edges.
REQ-020 div_start with div_b=0 SHALL skip DIV: the next edge writes LO<=all-ones and HI<=div_a, pulses div_done, and the FSM stays in IDLE.
REQ-021 W_HILO and div_start in the same IDLE cycle: the W_HILO write SHALL take effect, and the divide SHALL start and later overwrite HI/LO.
REQ-022 W_HILO=1 in DIV or FINISH SHALL write HI/LO, abort the divide (no div_done), and return to IDLE on that edge.
REQ-023 div_start while busy SHALL be ignored.
REQ-024 HI/LO SHALL change only on W_HILO writes, divide completion and reset; outputs SHALL be registered with no combinational bypass.

Reset
REQ-025 rst=1 SHALL immediately force HI=0, LO=0, busy=0, div_done=0, FSM=IDLE and the iteration count to 0, including mid-divide.
REQ-026 After rst deasserts, the first operation SHALL be accepted on the first following rising edge.

Configuration
REQ-027 With HILO_SIGNED_DIV_EN defined:
  - div_sign=1 SHALL divide magnitudes.
  - The quotient SHALL be negated when the operand signs differ.
  - The remainder SHALL take the dividend's sign; latency is unchanged.
REQ-028 With HILO_SIGNED_DIV_EN undefined, div_sign SHALL be ignored and all divides SHALL be unsigned.

Structure
REQ-029 FSM state encodings, LENGTH default and iteration-count width SHALL be defined in the shared header head.v.
REQ-030 The shift-subtract datapath SHALL be one sub-module, div_iter; HI/LO registers and the FSM SHALL stay in hilo_unit.

Verification
REQ-031 Write: W_HILO=1, Write_HI=32'h1234_5678, Write_LO=32'h9ABC_DEF0 -> next cycle HI/LO hold those values and busy=0.
REQ-032 Unsigned divide: div_a=100, div_b=7, div_sign=0 -> after 34 edges LO=14, HI=2, one div_done pulse, busy high for 33 cycles.
REQ-033 Divide by zero: div_a=32'h0000_0055, div_b=0 -> next edge LO=32'hFFFF_FFFF, HI=32'h0000_0055, busy never asserted.
REQ-034 Signed divide (macro on): div_a=-7, div_b=2, div_sign=1 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1).
REQ-035 Abort: start 100/7, then at cycle 10 W_HILO with HI=1, LO=2 -> HI=1, LO=2, no div_done, busy=0 next cycle.
REQ-036 Reset mid-divide: rst at cycle 5 of a divide -> HI=LO=0 and busy=0 immediately, with no div_done afterwards.

Source files
------------

// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: FSM state encoding, default width
// and the sizing rule for the divide iteration counter.
package hilo_unit_pkg;

    localparam int unsigned HILO_LENGTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic int unsigned iter_width(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/hilo_unit_div_iter.sv
// One restoring shift-subtract step of an unsigned LENGTH-bit divide.
// The dividend is shifted out of quo_in MSB-first while quotient bits shift in.
module div_iter
    import hilo_unit_pkg::*;
#(
    parameter int unsigned LENGTH = HILO_LENGTH
) (
    input  logic [LENGTH-1:0] rem_in,
    input  logic [LENGTH-1:0] quo_in,
    input  logic [LENGTH-1:0] divisor,
    output logic [LENGTH-1:0] rem_out,
    output logic [LENGTH-1:0] quo_out
);

    logic [LENGTH:0] shifted;
    logic            ge;

    always_comb begin
        shifted = {rem_in, quo_in[LENGTH-1]};
        ge      = (shifted >= {1'b0, divisor});
        // The partial remainder is always below the divisor, so the
        // subtraction fits in LENGTH bits whenever ge is set.
        rem_out = ge ? (shifted[LENGTH-1:0] - divisor) : shifted[LENGTH-1:0];
        quo_out = {quo_in[LENGTH-2:0], ge};
    end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with an iterative restoring divider.
// Define HILO_SIGNED_DIV_EN to honour div_sign (signed divide); otherwise all divides are unsigned.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int unsigned LENGTH = HILO_LENGTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              W_HILO,
    input  logic [LENGTH-1:0] Write_LO,
    input  logic [LENGTH-1:0] Write_HI,
    input  logic              div_start,
    input  logic              div_sign,
    input  logic [LENGTH-1:0] div_a,
    input  logic [LENGTH-1:0] div_b,
    output logic [LENGTH-1:0] LO,
    output logic [LENGTH-1:0] HI,
    output logic              busy,
    output logic              div_done
);

    localparam int unsigned         ITER_W    = iter_width(LENGTH);
    localparam logic [ITER_W-1:0]   LAST_ITER = ITER_W'(LENGTH - 1);

    state_t              state;
    logic [ITER_W-1:0]   iter;
    logic [LENGTH-1:0]   rem, quo, divisor;
    logic [LENGTH-1:0]   rem_next, quo_next;
    logic                neg_q, neg_r;
    logic                signed_op;
    logic                a_neg, b_neg;
    logic [LENGTH-1:0]   a_mag, b_mag;
    logic [LENGTH-1:0]   q_final, r_final;

`ifdef HILO_SIGNED_DIV_EN
    assign signed_op = div_sign;
`else
    logic unused_div_sign;
    assign unused_div_sign = div_sign;
    assign signed_op       = 1'b0;
`endif

    always_comb begin
        a_neg   = signed_op & div_a[LENGTH-1];
        b_neg   = signed_op & div_b[LENGTH-1];
        a_mag   = a_neg ? (-div_a) : div_a;
        b_mag   = b_neg ? (-div_b) : div_b;
        q_final = neg_q ? (-quo) : quo;
        r_final = neg_r ? (-rem) : rem;
    end

    div_iter #(.LENGTH(LENGTH)) u_div_iter (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (divisor),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            iter     <= '0;
            HI       <= '0;
            LO       <= '0;
            busy     <= 1'b0;
            div_done <= 1'b0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            div_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (W_HILO) begin
                        HI <= Write_HI;
                        LO <= Write_LO;
                    end
                    // A simultaneous divide is the later operation, so its
                    // divide-by-zero result wins over the W_HILO write.
                    if (div_start) begin
                        if (div_b == '0) begin
                            LO       <= '1;
                            HI       <= div_a;
                            div_done <= 1'b1;
                        end else begin
                            rem     <= '0;
                            quo     <= a_mag;
                            divisor <= b_mag;
                            neg_q   <= a_neg ^ b_neg;
                            neg_r   <= a_neg;
                            iter    <= '0;
                            state   <= DIV;
                            busy    <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    if (W_HILO) begin
                        HI    <= Write_HI;
                        LO    <= Write_LO;
                        iter  <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        if (iter == LAST_ITER) begin
                            iter  <= '0;
                            state <= FINISH;
                        end else begin
                            iter <= iter + ITER_W'(1);
                        end
                    end
                end
                FINISH: begin
                    if (W_HILO) begin
                        HI <= Write_HI;
                        LO <= Write_LO;
                    end else begin
                        LO       <= q_final;
                        HI       <= r_final;
                        div_done <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    iter  <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
